// File: rtl/ahb_matrix_out_arb_if.sv
// ---------------------------------------------------------------------------
// ahb_matrix_out_arb_if
//
// Purpose:
//   Bundles the signals exchanged between the AHB matrix input stages and
//   the round-robin arbiter of a single output stage.
//
// Signals:
//   req_in       [2:0]  per-input-port select toward this output stage
//   trans_in     [5:0]  per-port HTRANS, bits [2n+1:2n] belong to port n
//   burst_in     [8:0]  per-port HBURST, bits [3n+2:3n] belong to port n
//   lock_in      [2:0]  per-port HMASTLOCK (only with MATRIX_ARB_LOCK_EN)
//   HREADYM             output-port HREADY
//   addr_in_port [1:0]  registered address-phase owner
//   no_port             registered "no owner, output stage drives IDLE"
//   data_in_port [1:0]  registered data-phase owner
//   active_in    [2:0]  one-hot of the current address-phase owner
//
// Modports:
//   slave  - the arbiter (consumes requests, produces ownership)
//   master - the input-stage side (produces requests, consumes ownership)
//
// Configuration macro: MATRIX_ARB_LOCK_EN adds the lock_in vector.
// ---------------------------------------------------------------------------
interface ahb_matrix_out_arb_if;

  logic [2:0] req_in;
  logic [5:0] trans_in;
  logic [8:0] burst_in;
`ifdef MATRIX_ARB_LOCK_EN
  logic [2:0] lock_in;
`endif
  logic       HREADYM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [1:0] data_in_port;
  logic [2:0] active_in;

  // Arbiter view: request side in, ownership side out.
  modport slave (
    input  req_in,
    input  trans_in,
    input  burst_in,
`ifdef MATRIX_ARB_LOCK_EN
    input  lock_in,
`endif
    input  HREADYM,
    output addr_in_port,
    output no_port,
    output data_in_port,
    output active_in
  );

  // Input-stage view: drives requests, observes who owns the output.
  modport master (
    output req_in,
    output trans_in,
    output burst_in,
`ifdef MATRIX_ARB_LOCK_EN
    output lock_in,
`endif
    output HREADYM,
    input  addr_in_port,
    input  no_port,
    input  data_in_port,
    input  active_in
  );

endinterface

// File: rtl/ahb_matrix_out_arb.sv
// ---------------------------------------------------------------------------
// ahb_matrix_out_arb
//
// Purpose:
//   Round-robin arbiter for one output stage of a 3-input AHB bus matrix.
//   It decides which input port owns the address phase of the output port,
//   keeps a fixed-length burst together by counting its remaining beats,
//   keeps an undefined-length INCR burst together until it ends, and tracks
//   the data-phase owner one transfer behind the address-phase owner.
//
// Ports:
//   HCLK    in   AHB clock, all state changes on its rising edge
//   HRESET  in   synchronous, active-high reset
//   bus     ahb_matrix_out_arb_if.slave
//             in : req_in, trans_in, burst_in, HREADYM (and lock_in)
//             out: addr_in_port, no_port, data_in_port, active_in
//
// Configuration macro:
//   MATRIX_ARB_LOCK_EN - when defined, a locked transfer sequence
//   (HMASTLOCK) holds the grant until the owner issues IDLE with its lock
//   deasserted. When undefined, lock_in and the lock register do not exist.
// ---------------------------------------------------------------------------
module ahb_matrix_out_arb (
  input logic                 HCLK,
  input logic                 HRESET,
  ahb_matrix_out_arb_if.slave bus
);

  // AHB HTRANS encodings
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // AHB HBURST encodings
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  // Registered state
  logic [1:0] addr_q;
  logic [1:0] data_q;
  logic       no_port_q;
  logic [3:0] beat_cnt;
  logic [1:0] last_grant;

  // Current owner's view of the request inputs
  logic       owner_req;
  logic [1:0] owner_trans;
  logic [2:0] owner_burst;

  // Arbitration and next-state terms
  logic       owner_accept;
  logic       burst_end;
  logic       lock_block;
  logic       arb_ok;
  logic [1:0] grant_pick;
  logic [3:0] beat_nxt;
  logic [2:0] active_q;

`ifdef MATRIX_ARB_LOCK_EN
  logic       owner_lock;
  logic       hold_lock;
  logic       hold_lock_nxt;
`endif

  // Number of beats still to come after a NONSEQ of the given burst type.
  // SINGLE and undefined-length INCR have no counted tail, so they load 0.
  function automatic logic [3:0] burst_tail(input logic [2:0] burst);
    logic [3:0] tail;
    case (burst)
      BURST_WRAP4, BURST_INCR4:   tail = 4'd3;
      BURST_WRAP8, BURST_INCR8:   tail = 4'd7;
      BURST_WRAP16, BURST_INCR16: tail = 4'd15;
      BURST_SINGLE, BURST_INCR:   tail = 4'd0;
      default:                    tail = 4'd0;
    endcase
    return tail;
  endfunction

  // Round-robin search starting at the port after the last grant. The
  // caller only uses the result when at least one request is present.
  function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] last);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    logic [1:0] pick;
    case (last)
      2'd0: begin
        first  = 2'd1;
        second = 2'd2;
        third  = 2'd0;
      end
      2'd1: begin
        first  = 2'd2;
        second = 2'd0;
        third  = 2'd1;
      end
      default: begin
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
      end
    endcase
    if (req[first]) begin
      pick = first;
    end else if (req[second]) begin
      pick = second;
    end else begin
      pick = third;
    end
    return pick;
  endfunction

  // Select the request, HTRANS and HBURST of whichever port currently owns
  // the address phase.
  always_comb begin
    owner_req   = 1'b0;
    owner_trans = TRANS_IDLE;
    owner_burst = BURST_SINGLE;
`ifdef MATRIX_ARB_LOCK_EN
    owner_lock  = 1'b0;
`endif
    case (addr_q)
      2'd0: begin
        owner_req   = bus.req_in[0];
        owner_trans = bus.trans_in[1:0];
        owner_burst = bus.burst_in[2:0];
`ifdef MATRIX_ARB_LOCK_EN
        owner_lock  = bus.lock_in[0];
`endif
      end
      2'd1: begin
        owner_req   = bus.req_in[1];
        owner_trans = bus.trans_in[3:2];
        owner_burst = bus.burst_in[5:3];
`ifdef MATRIX_ARB_LOCK_EN
        owner_lock  = bus.lock_in[1];
`endif
      end
      2'd2: begin
        owner_req   = bus.req_in[2];
        owner_trans = bus.trans_in[5:4];
        owner_burst = bus.burst_in[8:6];
`ifdef MATRIX_ARB_LOCK_EN
        owner_lock  = bus.lock_in[2];
`endif
      end
      default: begin
        owner_req   = 1'b0;
        owner_trans = TRANS_IDLE;
        owner_burst = BURST_SINGLE;
      end
    endcase
  end

  // A transfer from the owner is only accepted when it really owns the
  // output (no_port low), still requests it, and the data phase advances.
  assign owner_accept = bus.HREADYM & ~no_port_q & owner_req;

  // The owner's transfer sequence may end this cycle: it stopped requesting,
  // went IDLE, issued a single transfer, is on the last counted beat, or
  // there simply is no owner.
  assign burst_end = ~owner_req
                   | (owner_trans == TRANS_IDLE)
                   | ((owner_trans == TRANS_NONSEQ) && (owner_burst == BURST_SINGLE))
                   | ((owner_trans == TRANS_SEQ) && (beat_cnt == 4'd1))
                   | no_port_q;

`ifdef MATRIX_ARB_LOCK_EN
  // The locked transfer that sets hold_lock is itself part of the locked
  // sequence, so it must already block re-arbitration in its own cycle;
  // otherwise the first locked SINGLE would hand the bus away before the
  // register catches up.
  assign lock_block = hold_lock | (owner_accept & owner_lock & owner_trans[1]);
`else
  assign lock_block = 1'b0;
`endif

  assign arb_ok     = bus.HREADYM & ~lock_block & burst_end;
  assign grant_pick = rr_pick(bus.req_in, last_grant);

  // Beat counter next value. A dropped request abandons any counted tail,
  // NONSEQ loads the tail of the new burst, SEQ counts down, BUSY and IDLE
  // leave it alone. With no owner nothing is accepted.
  always_comb begin
    beat_nxt = beat_cnt;
    if (!no_port_q) begin
      if (!owner_req) begin
        beat_nxt = 4'd0;
      end else begin
        case (owner_trans)
          TRANS_NONSEQ: beat_nxt = burst_tail(owner_burst);
          TRANS_SEQ:    beat_nxt = (beat_cnt != 4'd0) ? (beat_cnt - 4'd1) : beat_cnt;
          TRANS_BUSY:   beat_nxt = beat_cnt;
          default:      beat_nxt = beat_cnt;
        endcase
      end
    end
  end

  // Ownership registers. Nothing moves while the output port is stalled.
  // The data-phase owner always follows the address-phase owner on a
  // completing cycle. An arbitration point with no requests parks the
  // output (no_port) but leaves addr_in_port pointing at the old owner.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q     <= 2'd0;
      data_q     <= 2'd0;
      no_port_q  <= 1'b1;
      beat_cnt   <= 4'd0;
      last_grant <= 2'd2;
    end else if (bus.HREADYM) begin
      data_q   <= addr_q;
      beat_cnt <= beat_nxt;
      if (arb_ok) begin
        if (bus.req_in == 3'b000) begin
          no_port_q <= 1'b1;
        end else begin
          addr_q     <= grant_pick;
          last_grant <= grant_pick;
          no_port_q  <= 1'b0;
        end
      end
    end
  end

`ifdef MATRIX_ARB_LOCK_EN
  // Lock tracking: an accepted NONSEQ/SEQ with HMASTLOCK high starts or
  // continues the locked sequence; an accepted IDLE with HMASTLOCK low ends
  // it.
  always_comb begin
    hold_lock_nxt = hold_lock;
    if (owner_accept && owner_trans[1] && owner_lock) begin
      hold_lock_nxt = 1'b1;
    end else if (owner_accept && (owner_trans == TRANS_IDLE) && !owner_lock) begin
      hold_lock_nxt = 1'b0;
    end
  end

  // Lock register, frozen like the rest of the state on a stalled cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_lock <= 1'b0;
    end else if (bus.HREADYM) begin
      hold_lock <= hold_lock_nxt;
    end
  end
`endif

  // One-hot address-phase owner; all zero whenever the output is parked.
  always_comb begin
    active_q = 3'b000;
    if (!no_port_q) begin
      case (addr_q)
        2'd0:    active_q = 3'b001;
        2'd1:    active_q = 3'b010;
        2'd2:    active_q = 3'b100;
        default: active_q = 3'b000;
      endcase
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.data_in_port = data_q;
  assign bus.active_in    = active_q;

endmodule

// File: tb/tb_ahb_matrix_out_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb_matrix_out_arb
//
// Purpose:
//   Directed self-checking bench for ahb_matrix_out_arb. A behavioural
//   ownership model tracks owner, parked state, remaining beats and lock
//   in plain integers and is compared against the DUT on every falling
//   edge; literal expectations at key points pin both model and DUT.
//
// Configuration macro: MATRIX_ARB_LOCK_EN selects the locked expectations.
// ---------------------------------------------------------------------------
module tb_ahb_matrix_out_arb;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SQ   = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_WRAP4  = 3'd2;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

`ifdef MATRIX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;

  logic [2:0] req_drv;
  logic [5:0] trans_drv;
  logic [8:0] burst_drv;
  logic       ready_drv;
  logic [2:0] lock_drv;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model state: owner index, parked flag, data-phase owner, beats still
  // expected after the current one, last granted port, lock held.
  int m_owner;
  int m_data;
  int m_remain;
  int m_last;
  bit m_idle;
  bit m_lock;

  ahb_matrix_out_arb_if bus ();

  assign bus.req_in   = req_drv;
  assign bus.trans_in = trans_drv;
  assign bus.burst_in = burst_drv;
  assign bus.HREADYM  = ready_drv;
`ifdef MATRIX_ARB_LOCK_EN
  assign bus.lock_in  = lock_drv;
`endif

  ahb_matrix_out_arb dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [5:0] tr3(input logic [1:0] t0, input logic [1:0] t1,
                                     input logic [1:0] t2);
    return {t2, t1, t0};
  endfunction

  function automatic logic [8:0] bu3(input logic [2:0] b0, input logic [2:0] b1,
                                     input logic [2:0] b2);
    return {b2, b1, b0};
  endfunction

  // Total beats of a burst type; undefined-length INCR counts as one.
  function automatic int beats_of(input int b);
    case (b)
      2, 3:    return 4;
      4, 5:    return 8;
      6, 7:    return 16;
      default: return 1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the ownership model across one rising edge using the inputs
  // that were presented during the cycle.
  task automatic modelStep();
    int  o_tr;
    int  o_bu;
    bit  o_req;
    bit  acc;
    bit  lock_now;
    bit  ok;
    bit  found;
    int  p;
    if (HRESET) begin
      m_owner  = 0;
      m_data   = 0;
      m_idle   = 1'b1;
      m_remain = 0;
      m_last   = 2;
      m_lock   = 1'b0;
      return;
    end
    if (!ready_drv) return;
    o_req = req_drv[m_owner];
    o_tr  = int'((trans_drv >> (2 * m_owner)) & 6'h3);
    o_bu  = int'((burst_drv >> (3 * m_owner)) & 9'h7);
    acc   = !m_idle && o_req;
    lock_now = LOCK_EN && (m_lock || (acc && lock_drv[m_owner] && o_tr >= 2));
    ok = !lock_now && (m_idle || !o_req || o_tr == 0 || (o_tr == 2 && o_bu == 0) ||
                       (o_tr == 3 && m_remain == 1));
    if (acc) begin
      if (o_tr == 2) m_remain = beats_of(o_bu) - 1;
      else if (o_tr == 3 && m_remain > 0) m_remain--;
    end else if (!m_idle) begin
      m_remain = 0;
    end
    if (LOCK_EN && acc) begin
      if (o_tr >= 2 && lock_drv[m_owner]) m_lock = 1'b1;
      else if (o_tr == 0 && !lock_drv[m_owner]) m_lock = 1'b0;
    end
    m_data = m_owner;
    if (ok) begin
      if (req_drv == 3'b000) begin
        m_idle = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          p = (m_last + k) % 3;
          if (!found && req_drv[p]) begin
            found   = 1'b1;
            m_owner = p;
          end
        end
        m_last = m_owner;
        m_idle = 1'b0;
      end
    end
  endtask

  // Present one cycle of inputs, let the edge happen, update the model.
  task automatic applyStimulus(input bit rst, input logic [2:0] req, input logic [5:0] tr,
                               input logic [8:0] bu, input bit rdy, input logic [2:0] lk);
    @(negedge HCLK);
    #2;
    HRESET    = rst;
    req_drv   = req;
    trans_drv = tr;
    burst_drv = bu;
    ready_drv = rdy;
    lock_drv  = lk;
    @(posedge HCLK);
    #1;
    modelStep();
    cmp_en = 1'b1;
  endtask

  task automatic cyc(input logic [2:0] req, input logic [5:0] tr, input logic [8:0] bu);
    applyStimulus(1'b0, req, tr, bu, 1'b1, 3'b000);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 3'b000, 6'd0, 9'd0, 1'b1, 3'b000);
    applyStimulus(1'b1, 3'b000, 6'd0, 9'd0, 1'b1, 3'b000);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge HCLK) begin
    if (cmp_en) begin
      checkOutput("addr_in_port", int'(bus.addr_in_port), m_owner);
      checkOutput("no_port", int'(bus.no_port), int'(m_idle));
      checkOutput("data_in_port", int'(bus.data_in_port), m_data);
      checkOutput("active_in", int'(bus.active_in), m_idle ? 0 : (1 << m_owner));
    end
  end

  initial begin
    int exp_rot[4];
    int exp_lock[5];
    HRESET    = 1'b1;
    req_drv   = 3'b000;
    trans_drv = 6'd0;
    burst_drv = 9'd0;
    ready_drv = 1'b1;
    lock_drv  = 3'b000;

    // Reset values, then an idle cycle right after reset.
    doReset();
    checkOutput("rst_addr", int'(bus.addr_in_port), 0);
    checkOutput("rst_no_port", int'(bus.no_port), 1);
    checkOutput("rst_data", int'(bus.data_in_port), 0);
    checkOutput("rst_active", int'(bus.active_in), 0);
    cyc(3'b000, 6'd0, 9'd0);
    checkOutput("post_rst_active", int'(bus.active_in), 0);

    // Two single-transfer requesters: 0 then 1, data phase one edge behind.
    doReset();
    cyc(3'b011, tr3(T_NS, T_NS, T_IDLE), 9'd0);
    checkOutput("s29_addr0", int'(bus.addr_in_port), 0);
    checkOutput("s29_active0", int'(bus.active_in), 1);
    checkOutput("s29_model_owner0", m_owner, 0);
    cyc(3'b011, tr3(T_NS, T_NS, T_IDLE), 9'd0);
    checkOutput("s29_addr1", int'(bus.addr_in_port), 1);
    checkOutput("s29_data1", int'(bus.data_in_port), 0);
    cyc(3'b011, tr3(T_NS, T_NS, T_IDLE), 9'd0);
    checkOutput("s29_addr2", int'(bus.addr_in_port), 0);
    checkOutput("s29_data2", int'(bus.data_in_port), 1);

    // All three requesting singles rotate 0,1,2,0.
    doReset();
    exp_rot = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(3'b111, tr3(T_NS, T_NS, T_NS), 9'd0);
      checkOutput("rotation", int'(bus.addr_in_port), exp_rot[i]);
    end

    // Port0 INCR4 with port2 requesting from beat 2.
    doReset();
    cyc(3'b001, 6'd0, 9'd0);
    cyc(3'b001, tr3(T_NS, T_IDLE, T_IDLE), bu3(B_INCR4, B_SINGLE, B_SINGLE));
    cyc(3'b101, tr3(T_SQ, T_IDLE, T_NS), bu3(B_INCR4, B_SINGLE, B_SINGLE));
    cyc(3'b101, tr3(T_SQ, T_IDLE, T_NS), bu3(B_INCR4, B_SINGLE, B_SINGLE));
    checkOutput("incr4_hold", int'(bus.addr_in_port), 0);
    cyc(3'b101, tr3(T_SQ, T_IDLE, T_NS), bu3(B_INCR4, B_SINGLE, B_SINGLE));
    checkOutput("incr4_release", int'(bus.addr_in_port), 2);
    checkOutput("incr4_model", m_owner, 2);

    // Port1 INCR8 with a two-cycle stall at beat 3.
    doReset();
    cyc(3'b010, 6'd0, 9'd0);
    checkOutput("incr8_grant", int'(bus.addr_in_port), 1);
    cyc(3'b010, tr3(T_IDLE, T_NS, T_IDLE), bu3(B_SINGLE, B_INCR8, B_SINGLE));
    cyc(3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR8, B_SINGLE));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR8, B_SINGLE),
                    1'b0, 3'b000);
      checkOutput("incr8_stall_addr", int'(bus.addr_in_port), 1);
      checkOutput("incr8_stall_data", int'(bus.data_in_port), 1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR8, B_SINGLE));
    end
    checkOutput("incr8_beat7", int'(bus.addr_in_port), 1);
    cyc(3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR8, B_SINGLE));
    checkOutput("incr8_release", int'(bus.addr_in_port), 0);

    // Port0 WRAP4 abandons its burst by dropping req after beat 2.
    doReset();
    cyc(3'b001, 6'd0, 9'd0);
    cyc(3'b001, tr3(T_NS, T_IDLE, T_IDLE), bu3(B_WRAP4, B_SINGLE, B_SINGLE));
    cyc(3'b011, tr3(T_SQ, T_NS, T_IDLE), bu3(B_WRAP4, B_SINGLE, B_SINGLE));
    cyc(3'b010, tr3(T_SQ, T_NS, T_IDLE), bu3(B_WRAP4, B_SINGLE, B_SINGLE));
    checkOutput("wrap4_drop", int'(bus.addr_in_port), 1);
    checkOutput("wrap4_model_remain", m_remain, 0);

    // Undefined-length INCR holds through SEQ/BUSY, releases on IDLE.
    doReset();
    cyc(3'b001, 6'd0, 9'd0);
    cyc(3'b011, tr3(T_NS, T_NS, T_IDLE), bu3(B_INCR, B_SINGLE, B_SINGLE));
    cyc(3'b011, tr3(T_SQ, T_NS, T_IDLE), bu3(B_INCR, B_SINGLE, B_SINGLE));
    cyc(3'b011, tr3(T_BUSY, T_NS, T_IDLE), bu3(B_INCR, B_SINGLE, B_SINGLE));
    cyc(3'b011, tr3(T_SQ, T_NS, T_IDLE), bu3(B_INCR, B_SINGLE, B_SINGLE));
    checkOutput("incr_hold", int'(bus.addr_in_port), 0);
    cyc(3'b011, tr3(T_IDLE, T_NS, T_IDLE), bu3(B_INCR, B_SINGLE, B_SINGLE));
    checkOutput("incr_release", int'(bus.addr_in_port), 1);

    // Nobody requesting at an arbitration point parks the output.
    cyc(3'b010, tr3(T_IDLE, T_NS, T_IDLE), 9'd0);
    cyc(3'b000, 6'd0, 9'd0);
    checkOutput("park_addr", int'(bus.addr_in_port), 1);
    checkOutput("park_no_port", int'(bus.no_port), 1);
    checkOutput("park_active", int'(bus.active_in), 0);

    // Reset in the middle of a port1 INCR16 at beat 5.
    doReset();
    cyc(3'b010, 6'd0, 9'd0);
    cyc(3'b010, tr3(T_IDLE, T_NS, T_IDLE), bu3(B_SINGLE, B_INCR16, B_SINGLE));
    for (int i = 0; i < 3; i++) begin
      cyc(3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR16, B_SINGLE));
    end
    applyStimulus(1'b1, 3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR16, B_SINGLE),
                  1'b1, 3'b000);
    checkOutput("midrst_addr", int'(bus.addr_in_port), 0);
    checkOutput("midrst_data", int'(bus.data_in_port), 0);
    checkOutput("midrst_no_port", int'(bus.no_port), 1);
    checkOutput("midrst_active", int'(bus.active_in), 0);
    cyc(3'b011, tr3(T_NS, T_SQ, T_IDLE), bu3(B_SINGLE, B_INCR16, B_SINGLE));
    checkOutput("midrst_regrant", int'(bus.addr_in_port), 0);
    checkOutput("midrst_regrant_np", int'(bus.no_port), 0);

    // Port2 issues three locked singles while 0 and 1 request, then IDLE.
    doReset();
    cyc(3'b100, 6'd0, 9'd0);
    checkOutput("lock_grant", int'(bus.addr_in_port), 2);
`ifdef MATRIX_ARB_LOCK_EN
    exp_lock = '{2, 2, 2, 2, 0};
`else
    exp_lock = '{0, 1, 2, 0, 1};
`endif
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b111, tr3(T_NS, T_NS, T_NS), 9'd0, 1'b1, 3'b100);
      checkOutput("lock_seq", int'(bus.addr_in_port), exp_lock[i]);
    end
    for (int i = 3; i < 5; i++) begin
      applyStimulus(1'b0, 3'b111, tr3(T_NS, T_NS, T_IDLE), 9'd0, 1'b1, 3'b000);
      checkOutput("lock_seq", int'(bus.addr_in_port), exp_lock[i]);
    end

    @(negedge HCLK);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_matrix_out_arb.md
AHB_MATRIX_OUT_ARB -- requirements
Module: ahb_matrix_out_arb

Interface
REQ-001 HCLK  input  1  AHB system clock; all state updates on its rising edge.
REQ-002 HRESET  input  1  Reset; synchronous and active-high.
REQ-003 req_in  input  3  Per-input-port select toward this output stage (bit n = input port n).
REQ-004 trans_in  input  6  Per-port HTRANS; bits [2n+1:2n] belong to port n.
REQ-005 burst_in  input  9  Per-port HBURST; bits [3n+2:3n] belong to port n.
REQ-006 lock_in  input  3  Per-port HMASTLOCK (present only with MATRIX_ARB_LOCK_EN).
REQ-007 HREADYM  input  1  Output-port HREADY; high = current data phase completes this cycle.
REQ-008 addr_in_port  output  2  Registered address-phase owner (0..2; 3 never driven).
REQ-009 no_port  output  1  Registered; high = no owner, output stage drives IDLE.
REQ-010 data_in_port  output  2  Registered data-phase owner.
REQ-011 active_in  output  3  Combinational; bit n = (addr_in_port==n) & ~no_port.

Function
REQ-012 All registers SHALL hold their value in any cycle where HREADYM=0.
REQ-013 Arbitration point (arb_ok) SHALL be: HREADYM=1 & ~hold_lock & (owner req=0 | owner trans IDLE | owner trans NONSEQ with burst SINGLE | owner trans SEQ with beat_cnt=1 | no_port=1).
REQ-014 On arb_ok, next owner SHALL be the first requesting port searching round-robin from last_grant+1 modulo 3; last_grant SHALL update to the new owner.
REQ-015 On arb_ok with req_in=000, no_port SHALL be set to 1 and addr_in_port SHALL keep its old value.
REQ-016 Grant latency: request to addr_in_port/active_in change SHALL be exactly one HCLK edge after arb_ok.
REQ-017 Owner holding arb_ok false SHALL retain the grant even if other ports request.
REQ-018 beat_cnt (4 bits) SHALL load on accepted owner NONSEQ: INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15, SINGLE/INCR=0.
REQ-019 beat_cnt SHALL decrement on accepted owner SEQ when nonzero; BUSY SHALL not change it.
REQ-020 INCR (undefined length) SHALL hold the grant through SEQ/BUSY; release only on IDLE, owner NONSEQ-SINGLE, or req drop.
REQ-021 Owner req dropping mid-burst (beat_cnt>0) SHALL clear beat_cnt and permit arbitration in that cycle.
REQ-022 On any edge with HREADYM=1, data_in_port SHALL load addr_in_port.
REQ-023 Simultaneous requests from all three ports SHALL be granted in rotation 0,1,2,0 across successive arbitration points.

Reset
REQ-024 While HRESET=1 at a clock edge: addr_in_port=0, data_in_port=0, no_port=1, beat_cnt=0, last_grant=2, hold_lock=0.
REQ-025 active_in SHALL be 000 during and immediately after reset.
REQ-026 Reset asserted mid-burst SHALL abandon the burst; first post-reset grant SHALL go to lowest requesting port from 0.

Configuration
REQ-027 Macro MATRIX_ARB_LOCK_EN defined: hold_lock register sets on an accepted owner transfer with lock_in[owner]=1, clears on accepted owner IDLE with lock_in[owner]=0; hold_lock=1 forces arb_ok=0.
REQ-028 MATRIX_ARB_LOCK_EN undefined: lock_in port and hold_lock absent; hold_lock treated as 0.

Verification
REQ-029 Reset, req_in=011 both NONSEQ SINGLE, HREADYM=1 -> owner 0 first edge, owner 1 next edge, data_in_port lags by one edge.
REQ-030 Port0 INCR4 (NONSEQ + 3 SEQ), port2 requesting from beat 2 -> addr_in_port stays 0 until edge after beat_cnt=1 SEQ, then 2.
REQ-031 Port1 INCR8 with HREADYM low 2 cycles at beat 3 -> beat_cnt and owner frozen, grant released exactly after 8th beat.
REQ-032 Port0 WRAP4, req_in[0] drops after 2nd beat while port1 requests -> beat_cnt=0, owner=1 next edge.
REQ-033 LOCK_EN: port2 locked SINGLE x3 with ports 0/1 requesting -> owner stays 2 until IDLE with lock low; without macro -> rotation continues.
REQ-034 HRESET pulse during port1 INCR16 beat 5 -> all outputs at reset values, no_port=1, next grant lowest requester.
